pc_trap_monitor: RTL and testbench

Parametrised per-hart retirement monitor for N-tile Piton/Ariane testbenches. Each cycle it samples every hart's retired PC and compares it against programmable good-trap and bad-trap address sets. It tracks a per-hart retirement watchdog and captures magic-address "print" retirements into a character FIFO. It reports sticky per-hart status and a global PASS/FAIL verdict through ports, so the testbench top decides when to end simulation.

---
 rtl/pc_trap_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_pc_trap_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trap_monitor.sv
// Per-hart retirement monitor: good/bad trap detection, retirement watchdog,
// print-window character capture and a sticky PASS/FAIL verdict.
module pc_trap_monitor #(
    parameter int          NUM_HARTS   = 4,
    parameter int          PC_W        = 64,
    parameter int          NUM_GOOD    = 1,
    parameter int          NUM_BAD     = 1,
    parameter int          TMO_W       = 32,
    parameter logic [63:0] PRINT_BASE  = 64'h0000_0000_8000_0400,
    parameter int          PRINT_SHIFT = 9,
    parameter int          CHAR_DEPTH  = 16,
    parameter int          PASS_ANY    = 0,
    localparam int         HID_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [NUM_HARTS-1:0]      pc_vld,
    input  logic [NUM_HARTS*PC_W-1:0] pc,
    input  logic [NUM_HARTS-1:0]      hart_mask,
    input  logic [NUM_GOOD*PC_W-1:0]  good_addr,
    input  logic [NUM_GOOD-1:0]       good_en,
    input  logic [NUM_BAD*PC_W-1:0]   bad_addr,
    input  logic [NUM_BAD-1:0]        bad_en,
    input  logic [TMO_W-1:0]          tmo_limit,
    output logic [NUM_HARTS-1:0]      good_hit,
    output logic [NUM_HARTS-1:0]      bad_hit,
    output logic [NUM_HARTS-1:0]      tmo_hit,
    output logic                      pass,
    output logic                      fail,
    output logic [1:0]                fail_code,
    output logic                      char_vld,
    input  logic                      char_rdy,
    output logic [HID_W-1:0]          char_hart,
    output logic [7:0]                char_data,
    output logic                      char_ovf
);

    localparam int              PTR_W = $clog2(CHAR_DEPTH);
    localparam logic [PC_W-1:0] PBASE = PC_W'(PRINT_BASE);
    localparam logic [PC_W-1:0] PWIN  = PBASE >> PRINT_SHIFT;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    logic [NUM_HARTS-1:0]      s_vld;
    logic [NUM_HARTS*PC_W-1:0] s_pc;

    logic [NUM_HARTS-1:0] good_m_s, bad_m_s, prt_m_s;
    logic [NUM_HARTS-1:0] good_hit_r, bad_hit_r, tmo_hit_r;
    logic [NUM_HARTS-1:0] good_hit_nxt_s, bad_hit_nxt_s, tmo_hit_nxt_s;
    logic [TMO_W-1:0]     cnt_r     [NUM_HARTS];
    logic [TMO_W-1:0]     cnt_nxt_s [NUM_HARTS];
    logic [TMO_W-1:0]     cnt_inc_s [NUM_HARTS];

    state_t     state_r, state_nxt_s;
    logic       run_s, pass_cond_s, fail_cond_s;
    logic       pass_r, fail_r;
    logic [1:0] fail_code_r, fail_code_nxt_s;
    logic [NUM_HARTS-1:0] masked_good_s;

    logic             push_s, extra_s, wr_s, pop_s, full_s;
    logic [HID_W-1:0] sel_s;
    logic [7:0]       dat_s;
    logic [HID_W+7:0] mem_r [CHAR_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]   count_r, count_nxt_s;
    logic             char_vld_r, ovf_r;

    // Stage-1 capture of the retirement bus
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            s_vld <= '0;
            s_pc  <= '0;
        end else begin
            s_vld <= pc_vld;
            s_pc  <= pc;
        end
    end

    // Address compares against trap slots and the print window
    always_comb begin
        good_m_s = '0;
        bad_m_s  = '0;
        prt_m_s  = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            for (int k = 0; k < NUM_GOOD; k++) begin
                good_m_s[h] = good_m_s[h] | (s_vld[h] & good_en[k] &
                              (good_addr[k*PC_W +: PC_W] == s_pc[h*PC_W +: PC_W]));
            end
            for (int k = 0; k < NUM_BAD; k++) begin
                bad_m_s[h] = bad_m_s[h] | (s_vld[h] & bad_en[k] &
                             (bad_addr[k*PC_W +: PC_W] == s_pc[h*PC_W +: PC_W]));
            end
            prt_m_s[h] = s_vld[h] & ((s_pc[h*PC_W +: PC_W] >> PRINT_SHIFT) == PWIN);
        end
    end

    assign run_s = (state_r == ST_RUN);

    // Sticky hit vectors and per-hart watchdogs; all frozen outside RUN
    always_comb begin
        good_hit_nxt_s = good_hit_r | (good_m_s & ~bad_m_s & hart_mask & {NUM_HARTS{run_s}});
        bad_hit_nxt_s  = bad_hit_r  | (bad_m_s & hart_mask & {NUM_HARTS{run_s}});
        tmo_hit_nxt_s  = tmo_hit_r;
        for (int h = 0; h < NUM_HARTS; h++) begin
            cnt_inc_s[h] = cnt_r[h] + TMO_W'(1);
            cnt_nxt_s[h] = cnt_r[h];
            if (run_s && hart_mask[h] && !good_hit_r[h] && (tmo_limit != '0)) begin
                if (s_vld[h]) begin
                    cnt_nxt_s[h] = '0;
                end else if (cnt_r[h] != tmo_limit) begin
                    cnt_nxt_s[h]     = cnt_inc_s[h];
                    tmo_hit_nxt_s[h] = tmo_hit_r[h] | (cnt_inc_s[h] == tmo_limit);
                end else begin
                    // Holding at the limit: no wrap, the hit stays asserted
                    tmo_hit_nxt_s[h] = 1'b1;
                end
            end else begin
                cnt_nxt_s[h] = cnt_r[h];
            end
        end
    end

    // Hit and watchdog state registers
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            good_hit_r <= '0;
            bad_hit_r  <= '0;
            tmo_hit_r  <= '0;
            for (int h = 0; h < NUM_HARTS; h++) cnt_r[h] <= '0;
        end else begin
            good_hit_r <= good_hit_nxt_s;
            bad_hit_r  <= bad_hit_nxt_s;
            tmo_hit_r  <= tmo_hit_nxt_s;
            for (int h = 0; h < NUM_HARTS; h++) cnt_r[h] <= cnt_nxt_s[h];
        end
    end

    // Verdict next-state; FAIL wins over PASS in the same cycle
    always_comb begin
        masked_good_s   = good_hit_r & hart_mask;
        pass_cond_s     = (PASS_ANY != 0) ? (|masked_good_s)
                        : ((hart_mask != '0) && (masked_good_s == hart_mask));
        fail_cond_s     = (|bad_hit_r) | (|tmo_hit_r);
        state_nxt_s     = state_r;
        fail_code_nxt_s = fail_code_r;
        case (state_r)
            ST_RUN: begin
                if (fail_cond_s) begin
                    state_nxt_s     = ST_FAIL;
                    fail_code_nxt_s = (|bad_hit_r) ? 2'd1 : 2'd2;
                end else if (pass_cond_s) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PASS: state_nxt_s = ST_PASS;
            ST_FAIL: state_nxt_s = ST_FAIL;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Verdict state and registered verdict outputs
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            state_r     <= ST_RUN;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_code_r <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            pass_r      <= (state_nxt_s == ST_PASS);
            fail_r      <= (state_nxt_s == ST_FAIL);
            fail_code_r <= fail_code_nxt_s;
        end
    end

    // Print selection: lowest matching hart pushes, the rest count as lost
    always_comb begin
        push_s  = 1'b0;
        extra_s = 1'b0;
        sel_s   = '0;
        dat_s   = 8'd0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (prt_m_s[h] && !push_s) begin
                push_s = 1'b1;
                sel_s  = HID_W'(h);
                dat_s  = s_pc[h*PC_W+1 +: 8];
            end else begin
                extra_s = extra_s | prt_m_s[h];
            end
        end
        full_s      = (count_r == (PTR_W+1)'(CHAR_DEPTH));
        pop_s       = char_vld_r & char_rdy;
        wr_s        = push_s & (~full_s | pop_s);
        count_nxt_s = count_r + (PTR_W+1)'(wr_s) - (PTR_W+1)'(pop_s);
    end

    // Character FIFO storage, pointers and overflow flag
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            for (int i = 0; i < CHAR_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            char_vld_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= {sel_s, dat_s};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_nxt_s;
            char_vld_r <= (count_nxt_s != '0);
            ovf_r      <= ovf_r | extra_s | (push_s & full_s & ~pop_s);
        end
    end

    assign good_hit  = good_hit_r;
    assign bad_hit   = bad_hit_r;
    assign tmo_hit   = tmo_hit_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign fail_code = fail_code_r;
    assign char_vld  = char_vld_r;
    assign char_data = mem_r[rd_ptr_r][7:0];
    assign char_hart = mem_r[rd_ptr_r][HID_W+7:8];
    assign char_ovf  = ovf_r;

endmodule

// File: tb/tb_pc_trap_monitor.sv
// Directed bench for pc_trap_monitor with hand-computed expectations.
module tb_pc_trap_monitor;

    localparam logic [63:0] GOOD = 64'h0000_0000_8000_1000;
    localparam logic [63:0] BAD  = 64'h0000_0000_8000_2000;
    localparam logic [63:0] NOP  = 64'h0000_0000_8000_3000;
    localparam logic [63:0] PB   = 64'h0000_0000_8000_0400;

    logic         clk = 1'b0;
    logic         rst_l = 1'b1;
    logic [3:0]   pc_vld = 4'd0;
    logic [255:0] pc = '0;
    logic [3:0]   hart_mask = 4'hF;
    logic [63:0]  good_addr = GOOD;
    logic [0:0]   good_en = 1'b1;
    logic [63:0]  bad_addr = BAD;
    logic [0:0]   bad_en = 1'b1;
    logic [31:0]  tmo_limit = 32'd0;
    logic [3:0]   good_hit, bad_hit, tmo_hit;
    logic         pass, fail, char_vld, char_ovf;
    logic         char_rdy = 1'b0;
    logic [1:0]   fail_code, char_hart;
    logic [7:0]   char_data;

    int checks = 0;
    int errors = 0;

    pc_trap_monitor dut (
        .clk(clk), .rst_l(rst_l), .pc_vld(pc_vld), .pc(pc), .hart_mask(hart_mask),
        .good_addr(good_addr), .good_en(good_en), .bad_addr(bad_addr), .bad_en(bad_en),
        .tmo_limit(tmo_limit), .good_hit(good_hit), .bad_hit(bad_hit), .tmo_hit(tmo_hit),
        .pass(pass), .fail(fail), .fail_code(fail_code), .char_vld(char_vld),
        .char_rdy(char_rdy), .char_hart(char_hart), .char_data(char_data), .char_ovf(char_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic retire(input logic [3:0] v, input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] a2, input logic [63:0] a3);
        pc_vld = v;
        pc     = {a3, a2, a1, a0};
        step();
        pc_vld = 4'd0;
    endtask

    task automatic reset_dut();
        rst_l    = 1'b1;
        pc_vld   = 4'd0;
        char_rdy = 1'b0;
        step_n(2);
        rst_l = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_good"}, good_hit, 0);
        check({tag, "_bad"}, bad_hit, 0);
        check({tag, "_tmo"}, tmo_hit, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_code"}, fail_code, 0);
        check({tag, "_cvld"}, char_vld, 0);
        check({tag, "_chart"}, char_hart, 0);
        check({tag, "_cdata"}, char_data, 0);
        check({tag, "_covf"}, char_ovf, 0);
    endtask

    task automatic pop();
        char_rdy = 1'b1;
        step();
        char_rdy = 1'b0;
    endtask

    function automatic logic [63:0] pchar(input logic [7:0] c);
        return PB | ({56'd0, c} << 1);
    endfunction

    initial begin
        step_n(2);
        check_all_zero("reset");
        rst_l = 1'b0;
        step();

        // Pass: harts 0..2 first, then hart 3 completes the set
        retire(4'b0111, GOOD, GOOD, GOOD, NOP);
        step();
        check("pass_part_good", good_hit, 4'b0111);
        step();
        check("pass_part_pass", pass, 0);
        retire(4'b1000, NOP, NOP, NOP, GOOD);
        step();
        check("pass_full_good", good_hit, 4'hF);
        check("pass_c2_pass", pass, 0);
        step();
        check("pass_c3_pass", pass, 1);
        check("pass_c3_fail", fail, 0);
        retire(4'b0001, BAD, NOP, NOP, NOP);
        step_n(2);
        check("pass_frozen_bad", bad_hit, 0);
        check("pass_frozen_fail", fail, 0);

        // Bad trap on hart 2
        reset_dut();
        retire(4'b0100, NOP, NOP, BAD, NOP);
        step();
        check("bad_hit", bad_hit, 4'b0100);
        check("bad_c2_fail", fail, 0);
        step();
        check("bad_fail", fail, 1);
        check("bad_code", fail_code, 1);
        check("bad_pass", pass, 0);
        retire(4'hF, GOOD, GOOD, GOOD, GOOD);
        step_n(2);
        check("bad_good_frozen", good_hit, 0);

        // Good and bad in the same cycle on different harts
        reset_dut();
        retire(4'b0011, GOOD, BAD, NOP, NOP);
        step_n(2);
        check("conf_good", good_hit, 4'b0001);
        check("conf_bad", bad_hit, 4'b0010);
        check("conf_fail", fail, 1);
        check("conf_pass", pass, 0);
        check("conf_code", fail_code, 1);

        // One PC matching both slots only counts as bad
        reset_dut();
        good_addr = BAD;
        retire(4'b0001, BAD, NOP, NOP, NOP);
        step();
        check("both_good", good_hit, 0);
        check("both_bad", bad_hit, 4'b0001);
        good_addr = GOOD;

        // Watchdog expiry after five idle cycles
        hart_mask = 4'b0001;
        reset_dut();
        tmo_limit = 32'd5;
        retire(4'b0001, NOP, NOP, NOP, NOP);
        step_n(5);
        check("tmo_early", tmo_hit, 0);
        step();
        check("tmo_hit", tmo_hit, 4'b0001);
        step();
        check("tmo_fail", fail, 1);
        check("tmo_code", fail_code, 2);

        // Retiring every four cycles keeps the watchdog quiet
        tmo_limit = 32'd0;
        reset_dut();
        tmo_limit = 32'd5;
        for (int i = 0; i < 6; i++) begin
            retire(4'b0001, NOP, NOP, NOP, NOP);
            step_n(3);
        end
        check("tmo_kept_hit", tmo_hit, 0);
        check("tmo_kept_fail", fail, 0);

        // Lowering the limit below the running count never triggers
        tmo_limit = 32'd0;
        reset_dut();
        tmo_limit = 32'd5;
        retire(4'b0001, NOP, NOP, NOP, NOP);
        step_n(3);
        tmo_limit = 32'd1;
        step_n(10);
        check("tmo_lowered", tmo_hit, 0);
        tmo_limit = 32'd0;

        // Print path: "Hi" on hart 1 with the consumer stalled
        hart_mask = 4'd0;
        reset_dut();
        retire(4'b0010, NOP, pchar(8'h48), NOP, NOP);
        retire(4'b0010, NOP, pchar(8'h69), NOP, NOP);
        check("prt_lat_vld", char_vld, 1);
        step();
        check("prt_hart0", char_hart, 1);
        check("prt_data0", char_data, 8'h48);
        pop();
        check("prt_vld1", char_vld, 1);
        check("prt_hart1", char_hart, 1);
        check("prt_data1", char_data, 8'h69);
        pop();
        check("prt_empty", char_vld, 0);
        check("prt_ovf", char_ovf, 0);

        // Overflow: 17 pushes keep the first 16
        reset_dut();
        for (int i = 0; i < 17; i++) retire(4'b0001, pchar(8'h41 + 8'(i)), NOP, NOP, NOP);
        step_n(2);
        check("ovf_flag", char_ovf, 1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_data", char_data, 64'(8'h41 + 8'(i)));
            pop();
        end
        check("ovf_empty", char_vld, 0);

        // Push and pop together while full is not an overflow
        reset_dut();
        for (int i = 0; i < 16; i++) retire(4'b0001, pchar(8'h41 + 8'(i)), NOP, NOP, NOP);
        step_n(2);
        retire(4'b0001, pchar(8'h5A), NOP, NOP, NOP);
        pop();
        check("full_pp_ovf", char_ovf, 0);
        check("full_pp_head", char_data, 8'h42);
        for (int i = 0; i < 15; i++) pop();
        check("full_pp_last_vld", char_vld, 1);
        check("full_pp_last", char_data, 8'h5A);

        // Simultaneous prints on harts 0 and 2
        reset_dut();
        retire(4'b0101, pchar(8'h41), NOP, pchar(8'h42), NOP);
        step();
        check("sim_vld", char_vld, 1);
        check("sim_hart", char_hart, 0);
        check("sim_data", char_data, 8'h41);
        check("sim_ovf", char_ovf, 1);
        pop();
        check("sim_single", char_vld, 0);

        // Reset while failed with characters queued, then a clean pass
        hart_mask = 4'hF;
        reset_dut();
        retire(4'b0011, BAD, pchar(8'h51), NOP, NOP);
        step_n(2);
        check("mid_fail", fail, 1);
        check("mid_cvld", char_vld, 1);
        rst_l = 1'b1;
        step();
        check_all_zero("mid_reset");
        rst_l = 1'b0;
        step();
        retire(4'hF, GOOD, GOOD, GOOD, GOOD);
        step_n(2);
        check("mid_pass", pass, 1);
        check("mid_fail_clr", fail, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
